// File: rtl/a0_trace_fifo.sv
// Purpose: records each change of the CPU a0 register, tagged with a cycle stamp, in a small FIFO.
// Latency: a capture in cycle N shows at the head in cycle N+1 when the FIFO was empty (first-word fall-through).
// Backpressure: out_valid/out_ready drain; a capture that meets a full FIFO with no pop is dropped and sets sticky overflow.
module a0_trace_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int STAMP_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [DATA_WIDTH-1:0]      a0,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [STAMP_WIDTH-1:0]     out_stamp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [STAMP_WIDTH-1:0] stamp;
    } entry_t;

    entry_t                 mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [STAMP_WIDTH-1:0] stamp;
    logic [DATA_WIDTH-1:0]  prev;
    logic                   prev_valid;

    logic cap;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Change detect, and accept/drop decisions; full/empty come from count, never pointer equality.
    always_comb begin
        cap  = en && (!prev_valid || (a0 != prev));
        full = (count == FULL_CNT);
        pop  = out_valid && out_ready;
        push = cap && (!full || pop);
        drop = cap && full && !pop;
    end

    // Head presentation; storage is never reset, so gate it with out_valid.
    always_comb begin
        out_valid = (count != '0);
        out_data  = out_valid ? mem[rd_ptr].data  : '0;
        out_stamp = out_valid ? mem[rd_ptr].stamp : '0;
    end

    // Free-running stamp, change-detect history, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            stamp      <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            stamp <= stamp + 1'b1;
            // A dropped change still updates prev, so it is never re-detected later.
            if (en) begin
                prev       <= a0;
                prev_valid <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    // Entry storage; when full with a same-cycle pop, the tail slot is the one being freed.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= '{data: a0, stamp: stamp};
        end
    end

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Purpose: directed self-checking bench for a0_trace_fifo (default build plus a 4-bit-stamp build).
// Latency: inputs change #1 after a rising edge, outputs are sampled #1 after the next edge.
// Backpressure: out_ready is driven directly per step to exercise hold, drain and full push/pop.
module tb_a0_trace_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] a0;
    logic [31:0] out_data;
    logic [15:0] out_stamp;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  count;
    logic        overflow;

    logic        rst2;
    logic        en2;
    logic [31:0] a0_2;
    logic [31:0] out_data2;
    logic [3:0]  out_stamp2;
    logic        out_valid2;
    logic        out_ready2;
    logic [2:0]  count2;
    logic        overflow2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    a0_trace_fifo u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a0        (a0),
        .out_data  (out_data),
        .out_stamp (out_stamp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    a0_trace_fifo #(.DATA_WIDTH(32), .DEPTH(4), .STAMP_WIDTH(4)) u_dut_w (
        .clk       (clk),
        .rst       (rst2),
        .en        (en2),
        .a0        (a0_2),
        .out_data  (out_data2),
        .out_stamp (out_stamp2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .count     (count2),
        .overflow  (overflow2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; a0 = '0; out_ready = 1'b0;
        rst2 = 1'b1; en2 = 1'b0; a0_2 = '0; out_ready2 = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_stamp", 64'(out_stamp), 64'd0);

        // Fill and hold: 0x5 held 10 cycles captures once at stamp 0
        rst = 1'b0; en = 1'b1; a0 = 32'h5;
        repeat (10) tick();
        chk("hold_count", 64'(count), 64'd1);
        chk("hold_data", 64'(out_data), 64'h5);
        chk("hold_stamp", 64'(out_stamp), 64'd0);
        chk("hold_ovf", 64'(overflow), 64'd0);

        // Sequence 5,7,7,9 in cycles 10..13
        a0 = 32'h5; tick();
        a0 = 32'h7; tick();
        a0 = 32'h7; tick();
        a0 = 32'h9; tick();
        chk("seq_count", 64'(count), 64'd3);

        // Drain in order
        out_ready = 1'b1;
        chk("drain0_data", 64'(out_data), 64'h5);
        chk("drain0_stamp", 64'(out_stamp), 64'd0);
        tick();
        chk("drain1_data", 64'(out_data), 64'h7);
        chk("drain1_stamp", 64'(out_stamp), 64'd11);
        tick();
        chk("drain2_data", 64'(out_data), 64'h9);
        chk("drain2_stamp", 64'(out_stamp), 64'd13);
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_zero_data", 64'(out_data), 64'd0);
        out_ready = 1'b0;

        // Overflow: 20 distinct values into 16 entries
        for (int i = 1; i <= 20; i++) begin
            a0 = 32'(i);
            tick();
            if (i == 16) chk("ovf_before", 64'(overflow), 64'd0);
            if (i == 17) chk("ovf_after", 64'(overflow), 64'd1);
        end
        chk("ovf_count", 64'(count), 64'd16);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("ovf_drain%0d", i), 64'(out_data), 64'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("ovf_drain_count", 64'(count), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Reset mid-operation with count=5 and overflow=1
        for (int i = 21; i <= 25; i++) begin
            a0 = 32'(i);
            tick();
        end
        chk("mid_count", 64'(count), 64'd5);
        a0 = 32'h42;
        rst = 1'b1;
        tick();
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_count", 64'(count), 64'd1);
        chk("post_rst_data", 64'(out_data), 64'h42);
        chk("post_rst_stamp", 64'(out_stamp), 64'd0);

        // Full with same-cycle push and pop
        for (int i = 1; i <= 15; i++) begin
            a0 = 32'(100 + i);
            tick();
        end
        chk("full_count", 64'(count), 64'd16);
        a0 = 32'd200; out_ready = 1'b1;
        tick();
        chk("pp_count", 64'(count), 64'd16);
        chk("pp_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pp_drain%0d", i), 64'(out_data), (i == 15) ? 64'd200 : 64'(101 + i));
            tick();
        end
        out_ready = 1'b0;
        chk("pp_empty", 64'(out_valid), 64'd0);

        // Enable gating
        a0 = 32'h3; tick();
        chk("en_cap3", 64'(count), 64'd1);
        en = 1'b0; a0 = 32'h4; tick();
        chk("en_off", 64'(count), 64'd1);
        en = 1'b1; tick();
        chk("en_cap4", 64'(count), 64'd2);
        tick();
        chk("en_same", 64'(count), 64'd2);

        // Timestamp wrap on the 4-bit-stamp build: changes at cycles 0, 14, 17
        rst2 = 1'b0; en2 = 1'b1; a0_2 = 32'h1;
        repeat (14) tick();
        a0_2 = 32'h2;
        repeat (3) tick();
        a0_2 = 32'h3;
        tick();
        chk("wrap_count", 64'(count2), 64'd3);
        out_ready2 = 1'b1;
        chk("wrap0_stamp", 64'(out_stamp2), 64'd0);
        tick();
        chk("wrap1_data", 64'(out_data2), 64'h2);
        chk("wrap1_stamp", 64'(out_stamp2), 64'd14);
        tick();
        chk("wrap2_data", 64'(out_data2), 64'h3);
        chk("wrap2_stamp", 64'(out_stamp2), 64'd1);
        chk("wrap_ovf", 64'(overflow2), 64'd0);
        tick();
        chk("wrap_empty", 64'(out_valid2), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/a0_trace_fifo.md
Name: a0_trace_fifo

Overview:
- Downstream consumer of the CPU's a0 output. Records every change of a0, with a cycle timestamp, into a small FIFO.
- A valid/ready stream drains the FIFO to the display/bench side, so fast-changing a0 values (e.g. counter or PDF programs) are not missed when the consumer is slow.
- Sits beside the cpu top level, fed directly by its a0 port.

Parameters:
- DATA_WIDTH, 32, width of a0 and of each stored data entry.
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
- STAMP_WIDTH, 16, width of the free-running cycle timestamp.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; when 0, a0 is not sampled.
- a0  input  DATA_WIDTH  CPU register a0 value.
- out_data  output  DATA_WIDTH  head entry a0 value; 0 when empty.
- out_stamp  output  STAMP_WIDTH  head entry timestamp; 0 when empty.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head entry this cycle.
- count  output  $clog2(DEPTH)+1  number of stored entries.
- overflow  output  1  sticky flag: a capture was dropped because the FIFO was full.

Behaviour:
- Single clock domain. All state updates on the rising edge of clk.
- Reset is synchronous, active-high, and has priority over everything, including mid-operation. While rst=1, at the edge:
  - count=0, out_valid=0, overflow=0, out_data=0, out_stamp=0.
  - Read/write pointers=0, stamp counter=0, prev_valid=0, prev=0.
- Stamp counter: free-running. Value is 0 in the first cycle after rst deasserts, then +1 per cycle. Wraps modulo 2^STAMP_WIDTH.
- Capture condition, evaluated in cycle N: cap = en && (!prev_valid || a0 != prev).
  - On any cycle with en=1: prev<=a0 and prev_valid<=1, whether or not the push succeeds. A dropped change is therefore never re-detected.
  - With en=0, prev and prev_valid hold.
- Push: if cap, write {a0, stamp counter value in cycle N} to the tail. Accepted if count<DEPTH, or if a pop occurs in the same cycle.
- Dropped push: if cap, count==DEPTH and there is no pop, the entry is discarded and overflow<=1. Overflow stays 1 until rst.
- Pop: occurs when out_valid && out_ready; the head pointer advances. out_ready with out_valid=0 has no effect.
- First-word fall-through: out_data/out_stamp reflect the head entry whenever out_valid=1 and are forced to 0 when empty.
- Latency: a capture in cycle N is visible (out_valid=1, data presented) in cycle N+1 when the FIFO was empty. No combinational path from a0 to the outputs.
- count update rule:
  - push & pop → count unchanged.
  - push only → count+1.
  - pop only → count-1.
- Simultaneous push and pop:
  - When empty: not possible, since out_valid=0.
  - When full: both occur and count stays DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from count, not from pointer equality.
- Storage array needs no reset. Outputs must never expose unreset storage; they are gated by out_valid.

Test Plan:
- Fill, hold and reorder:
  - rst 2 cycles, then en=1, a0=0x5 held for 10 cycles, out_ready=0 → count=1, out_data=0x5, out_stamp=0, overflow=0.
  - Then a0 sequence 0x5,0x7,0x7,0x9 on consecutive cycles → count=3.
  - Drain with out_ready=1 → entries (0x5,0), (0x7,11), (0x9,13) in order; out_valid falls after the third pop.
- Overflow: DEPTH=16, out_ready=0, a0 takes 20 distinct values 1..20 on consecutive cycles → count=16, overflow=1 from the 17th capture's next cycle. Drain yields 1..16, and overflow stays 1 after draining.
- Full with same-cycle push/pop: FIFO full, same cycle a0 changes and out_ready=1 → count stays 16, overflow stays 0, new value becomes the last entry.
- Enable gating: en=0 while a0 goes 0x3→0x4 → no capture. en=1 with a0=0x4 and prev=0x3 → captured. en=1 with a0 unchanged from the last enabled sample → no capture.
- Reset mid-operation: count=5, overflow=1, then rst for 1 cycle → next cycle count=0, out_valid=0, out_data=0, overflow=0. First enabled cycle captures the current a0 with stamp=0.
- Timestamp wrap: STAMP_WIDTH=4, a0 changes at cycles 14 and 17 after reset → stamps 14 and 1.
